// File: rtl/bank_drain_sequencer.sv
// rtl/bank_drain_sequencer.sv - bank-major tile drain with credit-limited 2-deep tagged output FIFO
// Bank is the inner loop, entry the outer; at most two words are ever owed to the FIFO.
module bank_drain_sequencer #(
  parameter int BANK_COUNT = 32,
  parameter int TILE_SIZE  = 256,
  parameter int DATA_WIDTH = 16,
  parameter int SKIP_ZERO  = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [$clog2(TILE_SIZE):0]    entry_count,
  input  logic [1:0]                    bitwidth,
  output logic                          busy,
  output logic                          done,
  output logic                          rd_en,
  output logic [$clog2(BANK_COUNT)-1:0] rd_bank,
  output logic [$clog2(TILE_SIZE)-1:0]  rd_entry,
  input  logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(BANK_COUNT)-1:0] out_bank,
  output logic [$clog2(TILE_SIZE)-1:0]  out_entry,
  output logic [1:0]                    out_bitwidth,
  output logic [DATA_WIDTH-1:0]         out_data
);
  localparam int BW = $clog2(BANK_COUNT);
  localparam int EW = $clog2(TILE_SIZE);
  localparam int CW = EW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state;
  logic [CW-1:0]         count_q;
  logic [1:0]            bw_q;
  logic [BW-1:0]         bank_q;
  logic [EW-1:0]         entry_q;
  logic                  inflight;
  logic [BW-1:0]         tag_bank;
  logic [EW-1:0]         tag_entry;
  logic [BW-1:0]         fifo_bank  [2];
  logic [EW-1:0]         fifo_entry [2];
  logic [DATA_WIDTH-1:0] fifo_data  [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            occ;

  logic [CW-1:0] clamped;
  logic [2:0]    credit_used;
  logic          pop;
  logic          push;
  logic          last_read;

  assign clamped   = (entry_count > CW'(TILE_SIZE)) ? CW'(TILE_SIZE) : entry_count;
  assign out_valid = (occ != 2'd0);
  assign pop       = out_valid & out_ready;
  // pop implies occ >= 1, so this never underflows
  assign credit_used = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign rd_en     = (state == S_RUN) && (credit_used < 3'd2);
  assign push      = inflight && !((SKIP_ZERO != 0) && (rd_data == '0));
  assign last_read = (bank_q == BW'(BANK_COUNT - 1)) && ({1'b0, entry_q} == count_q - CW'(1));

  assign busy         = (state == S_RUN) || (state == S_FLUSH);
  assign done         = (state == S_DONE);
  assign rd_bank      = rd_en ? bank_q  : '0;
  assign rd_entry     = rd_en ? entry_q : '0;
  assign out_bank     = out_valid ? fifo_bank[rd_ptr]  : '0;
  assign out_entry    = out_valid ? fifo_entry[rd_ptr] : '0;
  assign out_data     = out_valid ? fifo_data[rd_ptr]  : '0;
  assign out_bitwidth = out_valid ? bw_q : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      count_q <= '0;
      bw_q    <= 2'b00;
      bank_q  <= '0;
      entry_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          count_q <= clamped;
          bw_q    <= bitwidth;
          bank_q  <= '0;
          entry_q <= '0;
          state   <= (clamped == '0) ? S_DONE : S_RUN;
        end
        S_RUN: if (rd_en) begin
          if (last_read) state <= S_FLUSH;
          if (bank_q == BW'(BANK_COUNT - 1)) begin
            bank_q  <= '0;
            entry_q <= entry_q + EW'(1);
          end else begin
            bank_q <= bank_q + BW'(1);
          end
        end
        S_FLUSH: if (!inflight && occ == 2'd0) state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read tags travel alongside the 1-cycle memory latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight  <= 1'b0;
      tag_bank  <= '0;
      tag_entry <= '0;
    end else begin
      inflight <= rd_en;
      if (rd_en) begin
        tag_bank  <= bank_q;
        tag_entry <= entry_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        fifo_bank[i]  <= '0;
        fifo_entry[i] <= '0;
        fifo_data[i]  <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        fifo_bank[wr_ptr]  <= tag_bank;
        fifo_entry[wr_ptr] <= tag_entry;
        fifo_data[wr_ptr]  <= rd_data;
        wr_ptr             <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_bank_drain_sequencer.sv
// tb/tb_bank_drain_sequencer.sv - randomized scoreboard bench for bank_drain_sequencer
// Two instances (zero-skip off/on) share stimulus; only the selected one is started.
module tb_bank_drain_sequencer;
  localparam int BC = 32;
  localparam int TS = 256;
  localparam int DW = 16;
  localparam int BW = 5;
  localparam int EW = 8;
  localparam int CW = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic [CW-1:0] entry_count = '0;
  logic [1:0]    bitwidth = 2'b00;
  logic          out_ready = 1'b1;
  int            sel = 0;
  int            mode = 0;
  int unsigned   seed = 0;
  bit            ready_rand = 1'b0;

  logic          busy0, done0, rd_en0, out_valid0, busy1, done1, rd_en1, out_valid1;
  logic [BW-1:0] rd_bank0, out_bank0, rd_bank1, out_bank1;
  logic [EW-1:0] rd_entry0, out_entry0, rd_entry1, out_entry1;
  logic [1:0]    out_bw0, out_bw1;
  logic [DW-1:0] rd_data0, out_data0, rd_data1, out_data1;

  function automatic logic [DW-1:0] model_word(input int md, input int b, input int e);
    int unsigned h;
    h = b * 40503 + e * 9973 + seed;
    h = h ^ (h >> 7);
    case (md)
      0:       return DW'(b + 1);
      1:       return (b % 2 == 1) ? DW'(b) : '0;
      2:       return DW'(h) | 16'h0001;
      default: return (h % 3 == 0) ? '0 : (DW'(h) | 16'h0001);
    endcase
  endfunction

  bank_drain_sequencer #(.BANK_COUNT(BC), .TILE_SIZE(TS), .DATA_WIDTH(DW), .SKIP_ZERO(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start && sel == 0), .entry_count(entry_count),
    .bitwidth(bitwidth), .busy(busy0), .done(done0), .rd_en(rd_en0), .rd_bank(rd_bank0),
    .rd_entry(rd_entry0), .rd_data(rd_data0), .out_valid(out_valid0), .out_ready(out_ready),
    .out_bank(out_bank0), .out_entry(out_entry0), .out_bitwidth(out_bw0), .out_data(out_data0));

  bank_drain_sequencer #(.BANK_COUNT(BC), .TILE_SIZE(TS), .DATA_WIDTH(DW), .SKIP_ZERO(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start && sel == 1), .entry_count(entry_count),
    .bitwidth(bitwidth), .busy(busy1), .done(done1), .rd_en(rd_en1), .rd_bank(rd_bank1),
    .rd_entry(rd_entry1), .rd_data(rd_data1), .out_valid(out_valid1), .out_ready(out_ready),
    .out_bank(out_bank1), .out_entry(out_entry1), .out_bitwidth(out_bw1), .out_data(out_data1));

  // Bank memory: 1-cycle read latency, garbage on idle cycles
  always @(posedge clk) begin
    rd_data0 <= rd_en0 ? model_word(mode, int'(rd_bank0), int'(rd_entry0)) : DW'($urandom);
    rd_data1 <= rd_en1 ? model_word(mode, int'(rd_bank1), int'(rd_entry1)) : DW'($urandom);
  end

  always @(posedge clk) begin
    #1;
    if (ready_rand) out_ready = ($urandom_range(0, 1) == 1);
  end

  logic          m_busy, m_done, m_rd_en, m_valid;
  logic [BW-1:0] m_rd_bank, m_bank;
  logic [EW-1:0] m_rd_entry, m_entry;
  logic [1:0]    m_bw;
  logic [DW-1:0] m_data;
  assign m_busy     = (sel == 1) ? busy1 : busy0;
  assign m_done     = (sel == 1) ? done1 : done0;
  assign m_rd_en    = (sel == 1) ? rd_en1 : rd_en0;
  assign m_rd_bank  = (sel == 1) ? rd_bank1 : rd_bank0;
  assign m_rd_entry = (sel == 1) ? rd_entry1 : rd_entry0;
  assign m_valid    = (sel == 1) ? out_valid1 : out_valid0;
  assign m_bank     = (sel == 1) ? out_bank1 : out_bank0;
  assign m_entry    = (sel == 1) ? out_entry1 : out_entry0;
  assign m_bw       = (sel == 1) ? out_bw1 : out_bw0;
  assign m_data     = (sel == 1) ? out_data1 : out_data0;

  int checks = 0;
  int passes = 0;
  logic [30:0] exp_q[$];

  task automatic chk(input bit ok, input string name, input longint got, input longint want);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, got, want);
  endtask

  // Monitor / scoreboard
  int          cyc = 0, pops = 0, rd_count = 0, done_count = 0, first_pop_cyc = 0, last_pop_cyc = 0;
  bit          busy_seen = 1'b0, held = 1'b0;
  logic [30:0] held_word, last_word, got_word, want_word;
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      got_word = {m_bank, m_entry, m_bw, m_data};
      if (held) chk(m_valid && got_word == held_word, "stall_stable", got_word, held_word);
      if (m_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_output", got_word, 0);
        end else begin
          want_word = exp_q.pop_front();
          chk(got_word == want_word, "output_word", got_word, want_word);
        end
        pops++;
        if (pops == 1) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
        last_word = got_word;
      end
      held = m_valid && !out_ready;
      held_word = got_word;
      if (m_rd_en) rd_count++;
      if (m_done) done_count++;
      if (m_busy) busy_seen = 1'b1;
    end else begin
      held = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int start_cyc = 0;
  task automatic begin_drain(input int s, input int cnt, input int md);
    int n;
    logic [DW-1:0] w;
    step();
    sel = s;
    mode = md;
    seed = $urandom;
    bitwidth = 2'($urandom_range(0, 3));
    entry_count = CW'(cnt);
    n = (cnt > TS) ? TS : cnt;
    for (int e = 0; e < n; e++)
      for (int b = 0; b < BC; b++) begin
        w = model_word(md, b, e);
        if (!(s == 1 && w == '0)) exp_q.push_back({BW'(b), EW'(e), bitwidth, w});
      end
    pops = 0; rd_count = 0; done_count = 0; busy_seen = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic finish_drain(input int bound, input string name);
    int n = 0;
    while (done_count == 0 && n < bound) begin
      step();
      n++;
    end
    chk(done_count != 0, {name, "_done_seen"}, done_count, 1);
    chk(exp_q.size() == 0, {name, "_all_outputs"}, exp_q.size(), 0);
    repeat (2) step();
    chk(done_count == 1 && !m_busy, {name, "_single_done_idle"}, done_count, 1);
    exp_q.delete();
  endtask

  task automatic chk_all_zero(input string name, input int s);
    sel = s;
    chk({m_busy, m_done, m_rd_en, m_valid} == 4'b0, {name, "_ctrl_zero"}, {m_busy, m_done, m_rd_en, m_valid}, 0);
    chk({m_rd_bank, m_rd_entry, m_bank, m_entry, m_bw, m_data} == '0, {name, "_bus_zero"},
        {m_rd_bank, m_rd_entry, m_bank, m_entry, m_bw, m_data}, 0);
  endtask

  int n_wait, done_before;
  initial begin
    repeat (3) step();
    chk_all_zero("reset_dut0", 0);
    chk_all_zero("reset_dut1", 1);
    rst_n = 1'b1;
    step();

    // 1: count=1, full throughput, first output at T+3
    out_ready = 1'b1;
    begin_drain(0, 1, 0);
    chk(m_rd_en && m_rd_bank == 0 && m_rd_entry == 0, "t1_first_read", m_rd_en, 1);
    finish_drain(200, "t1");
    chk(first_pop_cyc == start_cyc + 3, "t1_first_valid_latency", first_pop_cyc - start_cyc, 3);
    chk(pops == 32 && last_pop_cyc - first_pop_cyc == 31, "t1_one_per_cycle", last_pop_cyc - first_pop_cyc, 31);

    // 2: count=2, stalled for 10+ cycles
    out_ready = 1'b0;
    begin_drain(0, 2, 2);
    repeat (11) step();
    chk(rd_count == 2, "t2_reads_while_stalled", rd_count, 2);
    out_ready = 1'b1;
    finish_drain(400, "t2");
    chk(pops == 64, "t2_output_count", pops, 64);

    // 3: count=0
    begin_drain(0, 0, 0);
    chk(m_done, "t3_done_at_T1", m_done, 1);
    finish_drain(20, "t3");
    chk(rd_count == 0 && !busy_seen, "t3_no_reads_no_busy", rd_count, 0);

    // 4: zero-skip, even banks return 0
    begin_drain(1, 1, 1);
    finish_drain(200, "t4");
    chk(pops == 16, "t4_odd_banks_only", pops, 16);

    // 5: asynchronous reset mid-drain at entry 3
    ready_rand = 1'b1;
    begin_drain(0, 10, 2);
    n_wait = 0;
    while (!(m_rd_en && m_rd_entry == 3) && n_wait < 2000) begin
      step();
      n_wait++;
    end
    chk(n_wait < 2000, "t5_reached_entry3", n_wait, 0);
    done_before = done_count;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("t5_async_reset", 0);
    exp_q.delete();
    repeat (2) step();
    chk(done_count == done_before, "t5_no_done", done_count, done_before);
    rst_n = 1'b1;
    ready_rand = 1'b0;
    out_ready = 1'b1;
    begin_drain(0, 1, 0);
    finish_drain(200, "t5_restart");
    chk(first_pop_cyc == start_cyc + 3, "t5_restart_latency", first_pop_cyc - start_cyc, 3);

    // 6: clamp 300 -> 256, second start ignored
    ready_rand = 1'b1;
    begin_drain(0, 300, 2);
    repeat (50) step();
    entry_count = CW'(5);
    start = 1'b1;
    step();
    start = 1'b0;
    finish_drain(40000, "t6");
    chk(pops == 8192, "t6_output_count", pops, 8192);
    chk(last_word[30:18] == {5'd31, 8'd255}, "t6_last_tag", last_word[30:18], {5'd31, 8'd255});

    // Random drains on both instances
    for (int i = 0; i < 6; i++) begin
      begin_drain(i % 2, $urandom_range(0, 12), (i % 2 == 1) ? 3 : 2);
      finish_drain(3000, "rand");
    end
    ready_rand = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
